// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: multi-cycle data-memory stage with wait states.
// A load/store seen in IDLE is latched, the controller stalls the pipeline for
// LATENCY cycles, and the result (readdata/fault) is presented for one cycle in
// DONE with stall low so the CPU advances on that edge.
//
// Handshake: the CPU holds memread/memwrite (and addr/writedata) as a level
// request while o_stall is high. The access is complete on the cycle where the
// controller is in DONE (o_stall low). The request still visible in DONE belongs
// to the finished instruction and is not restarted; a new access can start on the
// following IDLE cycle.
module data_mem_ctrl #(
    parameter int DEPTH   = 128,  // number of 32-bit words, at least 2
    parameter int LATENCY = 2     // stall cycles per access, 1..15
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_writedata,
    input  logic        i_memread,
    input  logic        i_memwrite,
    output logic [31:0] o_readdata,
    output logic        o_stall,
    output logic        o_fault,
    output logic [1:0]  o_state     // FSM state for observation: 0 IDLE, 1 WAIT, 2 DONE
);

    localparam int          IDX_W   = $clog2(DEPTH);
    localparam logic [29:0] DEPTH_W = 30'(DEPTH);
    localparam logic [3:0]  CNT_INI = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef logic [31:0] mem_t [DEPTH];

    // Power-up contents: word i holds i. Reset never touches the array.
    function automatic mem_t mem_init();
        mem_t m;
        for (int i = 0; i < DEPTH; i++) begin
            m[i] = 32'(i);
        end
        return m;
    endfunction

    mem_t        r_mem = mem_init();

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_is_write;
    logic [31:0] r_readdata;
    logic        r_fault;

    logic        w_req;
    logic        w_finish;
    logic        w_from_idle;
    logic [31:0] w_op_addr;
    logic [31:0] w_op_wdata;
    logic        w_op_write;
    logic        w_bad;
    logic [IDX_W-1:0] w_idx;

    // A request with both strobes set is a store.
    assign w_req = i_memread | i_memwrite;

    // With LATENCY=1 the access completes straight out of IDLE, so the live
    // inputs are the operands; otherwise the latched copies are used.
    assign w_from_idle = (LATENCY == 1) && (r_state == S_IDLE) && w_req;
    assign w_finish    = w_from_idle || ((r_state == S_WAIT) && (r_cnt == 4'd1));
    assign w_op_addr   = w_from_idle ? i_addr      : r_addr;
    assign w_op_wdata  = w_from_idle ? i_writedata : r_wdata;
    assign w_op_write  = w_from_idle ? i_memwrite  : r_is_write;

    // Misaligned or beyond the array: no wrap-around, the access just faults.
    assign w_bad = (w_op_addr[1:0] != 2'b00) || (w_op_addr[31:2] >= DEPTH_W);
    assign w_idx = w_op_addr[IDX_W+1:2];

    assign o_stall    = !i_rst && (((r_state == S_IDLE) && w_req) || (r_state == S_WAIT));
    assign o_readdata = r_readdata;
    assign o_fault    = r_fault;
    assign o_state    = r_state;

    // Access sequencer with registered result outputs (valid only in DONE).
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_readdata <= 32'd0;
            r_fault    <= 1'b0;
        end else begin
            r_readdata <= 32'd0;
            r_fault    <= 1'b0;
            if (w_finish) begin
                r_fault <= w_bad;
                if (!w_op_write && !w_bad) begin
                    r_readdata <= r_mem[w_idx];
                end
            end
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_addr     <= i_addr;
                        r_wdata    <= i_writedata;
                        r_is_write <= i_memwrite;
                        r_cnt      <= CNT_INI;
                        r_state    <= (LATENCY > 1) ? S_WAIT : S_DONE;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Store commit on the edge into DONE; a reset on that edge abandons it.
    always_ff @(posedge i_clk) begin
        if (!i_rst && w_finish && w_op_write && !w_bad) begin
            r_mem[w_idx] <= w_op_wdata;
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed cases plus randomized loads/stores for
// data_mem_ctrl (LATENCY=2, DEPTH=128) against a word-array reference model.
module tb_data_mem_ctrl;

    localparam int DEPTH   = 128;
    localparam int LATENCY = 2;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] writedata;
    logic        memread;
    logic        memwrite;
    logic [31:0] readdata;
    logic        stall;
    logic        fault;
    logic [1:0]  state;

    int n_checks;
    int n_errors;

    logic [31:0] model_mem [DEPTH];
    logic [31:0] exp_q[$];

    data_mem_ctrl #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_addr      (addr),
        .i_writedata (writedata),
        .i_memread   (memread),
        .i_memwrite  (memwrite),
        .o_readdata  (readdata),
        .o_stall     (stall),
        .o_fault     (fault),
        .o_state     (state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic is_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= 32'(DEPTH));
    endfunction

    // One complete access starting in an IDLE cycle. Ends in the following IDLE
    // cycle with the request dropped and the post-DONE outputs checked.
    task automatic do_access(input logic rd, input logic wr,
                             input logic [31:0] a, input logic [31:0] d,
                             input logic scramble);
        logic        bad;
        logic [31:0] exp_rd;
        bad    = is_bad(a);
        exp_rd = 32'd0;
        if (!bad && !wr) exp_rd = model_mem[a[8:2]];
        exp_q.push_back(exp_rd);

        memread   = rd;
        memwrite  = wr;
        addr      = a;
        writedata = d;
        #1;
        check("stall_first", {31'd0, stall}, 32'd1);
        for (int c = 1; c < LATENCY; c++) begin
            tick();
            if (scramble) begin
                addr      = $urandom;
                writedata = $urandom;
                memread   = 1'($urandom_range(0, 1));
                memwrite  = 1'($urandom_range(0, 1));
                #1;
            end
            check("stall_wait", {31'd0, stall}, 32'd1);
        end
        tick();
        check("done_stall", {31'd0, stall}, 32'd0);
        check("done_readdata", readdata, exp_q.pop_front());
        check("done_fault", {31'd0, fault}, {31'd0, bad});
        if (wr && !bad) model_mem[a[8:2]] = d;

        tick();
        memread  = 1'b0;
        memwrite = 1'b0;
        #1;
        check("after_stall", {31'd0, stall}, 32'd0);
        check("after_readdata", readdata, 32'd0);
        check("after_fault", {31'd0, fault}, 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic        rd;
        logic        wr;
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'(i);

        // Reset, with a request present to show stall is held low.
        rst       = 1'b1;
        addr      = 32'h8;
        writedata = 32'd0;
        memread   = 1'b1;
        memwrite  = 1'b0;
        tick();
        check("rst_stall", {31'd0, stall}, 32'd0);
        tick();
        memread = 1'b0;
        rst     = 1'b0;
        #1;
        check("rst_readdata", readdata, 32'd0);
        check("rst_fault", {31'd0, fault}, 32'd0);
        check("rst_state", {30'd0, state}, 32'd0);

        // Idle for 10 cycles.
        for (int i = 0; i < 10; i++) begin
            check("idle_stall", {31'd0, stall}, 32'd0);
            check("idle_readdata", readdata, 32'd0);
            check("idle_fault", {31'd0, fault}, 32'd0);
            tick();
        end

        // Directed cases.
        do_access(1'b1, 1'b0, 32'h8, 32'd0, 1'b0);             // read word 2
        do_access(1'b1, 1'b0, 32'h10, 32'd0, 1'b0);            // word 4 before store
        do_access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
        do_access(1'b1, 1'b0, 32'h10, 32'd0, 1'b0);            // DEADBEEF
        do_access(1'b1, 1'b0, 32'h6, 32'd0, 1'b0);             // misaligned
        do_access(1'b1, 1'b0, 32'h4, 32'd0, 1'b0);             // word 1 intact
        do_access(1'b0, 1'b1, 32'h200, 32'h1234, 1'b0);        // out of range
        do_access(1'b1, 1'b0, 32'h0, 32'd0, 1'b0);             // word 0 still 0
        do_access(1'b1, 1'b1, 32'h0C, 32'h55AA55AA, 1'b0);     // both set = store
        do_access(1'b1, 1'b0, 32'h0C, 32'd0, 1'b0);
        do_access(1'b1, 1'b0, 32'h1FC, 32'd0, 1'b0);           // last word

        // Reset in WAIT abandons the store.
        memwrite  = 1'b1;
        addr      = 32'h20;
        writedata = 32'hAA;
        #1;
        check("rmid_stall0", {31'd0, stall}, 32'd1);
        tick();
        check("rmid_state_wait", {30'd0, state}, 32'd1);
        rst      = 1'b1;
        memwrite = 1'b0;
        #1;
        check("rmid_stall_rst", {31'd0, stall}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("rmid_state_idle", {30'd0, state}, 32'd0);
        check("rmid_stall", {31'd0, stall}, 32'd0);
        check("rmid_fault", {31'd0, fault}, 32'd0);
        do_access(1'b1, 1'b0, 32'h20, 32'd0, 1'b0);            // word 8 still 8

        // Randomized accesses, inputs scrambled during WAIT.
        for (int t = 0; t < 60; t++) begin
            case ($urandom_range(0, 9))
                0:       a = ($urandom_range(0, DEPTH - 1) << 2) | 32'($urandom_range(1, 3));
                1:       a = 32'(DEPTH * 4) + ($urandom_range(0, 255) << 2);
                2:       a = $urandom | 32'h8000_0000;
                default: a = $urandom_range(0, 15) << 2;       // small set to hit reuse
            endcase
            case ($urandom_range(0, 2))
                0:       begin rd = 1'b1; wr = 1'b0; end
                1:       begin rd = 1'b0; wr = 1'b1; end
                default: begin rd = 1'b1; wr = 1'b1; end
            endcase
            do_access(rd, wr, a, $urandom, 1'b1);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                tick();
                check("gap_stall", {31'd0, stall}, 32'd0);
                check("gap_readdata", readdata, 32'd0);
            end
        end

        // Final readback of the low words touched by random stores.
        for (int i = 0; i < 16; i++) begin
            do_access(1'b1, 1'b0, 32'(i) << 2, 32'd0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
